wbpipe_slice: RTL and testbench

- Registered pipeline slice for the narrow (SMALL_DW) Wishbone pipelined bus.
- Sits directly downstream of the wide-to-narrow downsizer and upstream of narrow peripherals/interconnect.
- Breaks every combinational path: request path through a skid buffer, return path (ack/data/err) through a register stage.
- Tracks outstanding requests and handles bus aborts and errors cleanly.

---
 rtl/wbpipe_pkg.sv | 14 +
 rtl/wbpipe_skid.sv | 65 ++++++
 rtl/wbpipe_slice.sv | 134 +++++++++++++
 tb/tb_wbpipe_slice.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbpipe_pkg.sv
// Shared types and defaults for the narrow Wishbone pipeline slice.
package wbpipe_pkg;
  localparam int WB_AW       = 30;
  localparam int WB_DW       = 32;
  localparam int LGDEPTH_DEF = 4;
  localparam int TIMEOUT_DEF = 1024;

  typedef struct packed {
    logic                 we;
    logic [WB_AW-1:0]     addr;
    logic [WB_DW-1:0]     data;
    logic [WB_DW/8-1:0]   sel;
  } wb_req_t;
endpackage

// File: rtl/wbpipe_skid.sv
// One-entry skid buffer in front of a registered output stage; flush empties both.
module wbpipe_skid
  import wbpipe_pkg::*;
#(
  parameter type T = wb_req_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic in_valid_i,
  input  T     in_data_i,
  input  logic out_ready_i,
  output logic out_valid_o,
  output T     out_data_o,
  output logic outv_d_o,
  output logic skv_d_o
);
  logic outv_q, outv_d, skv_q, skv_d, adv;
  T     out_q, out_d, sk_q, sk_d;

  always_comb begin
    outv_d = outv_q;
    out_d  = out_q;
    skv_d  = skv_q;
    sk_d   = sk_q;
    adv    = !outv_q || out_ready_i;
    if (flush_i) begin
      outv_d = 1'b0;
      skv_d  = 1'b0;
    end else if (adv) begin
      // skid entry is older than anything arriving now, so it goes out first
      if (skv_q) begin
        outv_d = 1'b1;
        out_d  = sk_q;
        skv_d  = in_valid_i;
        if (in_valid_i) sk_d = in_data_i;
      end else begin
        outv_d = in_valid_i;
        if (in_valid_i) out_d = in_data_i;
      end
    end else if (in_valid_i) begin
      skv_d = 1'b1;
      sk_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outv_q <= 1'b0;
      skv_q  <= 1'b0;
      out_q  <= '0;
      sk_q   <= '0;
    end else begin
      outv_q <= outv_d;
      skv_q  <= skv_d;
      out_q  <= out_d;
      sk_q   <= sk_d;
    end
  end

  assign out_valid_o = outv_q;
  assign out_data_o  = out_q;
  assign outv_d_o    = outv_d;
  assign skv_d_o     = skv_d;
endmodule

// File: rtl/wbpipe_slice.sv
// Registered Wishbone pipelined slice for the narrow bus: skid on requests, register on returns.
// Define WBPIPE_SLICE_TIMEOUT_EN to force a bus error on requests left unacked for TIMEOUT cycles.
module wbpipe_slice
  import wbpipe_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int LGDEPTH = LGDEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_scyc,
  input  logic            i_sstb,
  input  logic            i_swe,
  input  logic [AW-1:0]   i_saddr,
  input  logic [DW-1:0]   i_sdata,
  input  logic [DW/8-1:0] i_ssel,
  output logic            o_sstall,
  output logic            o_sack,
  output logic [DW-1:0]   o_sdata,
  output logic            o_serr,
  output logic            o_mcyc,
  output logic            o_mstb,
  output logic            o_mwe,
  output logic [AW-1:0]   o_maddr,
  output logic [DW-1:0]   o_mdata,
  output logic [DW/8-1:0] o_msel,
  input  logic            i_mstall,
  input  logic            i_mack,
  input  logic            i_merr,
  input  logic [DW-1:0]   i_mdata
);
  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] sel;
  } req_t;

  localparam logic [LGDEPTH:0] CNT_MAX = (LGDEPTH+1)'((1 << LGDEPTH) - 1);

  logic [LGDEPTH-1:0] cnt_q, cnt_d;
  logic [LGDEPTH:0]   tot_d;
  logic               mcyc_q, mcyc_d, stall_q, stall_d, abort_q, abort_d;
  logic               sack_q, sack_d, serr_q, serr_d;
  logic [DW-1:0]      sdata_q;
  logic               acc, issue, ack_ok, err_ev, flush, outv, outv_d, skv_d;
  req_t               in_req, out_req;

  assign in_req = {i_swe, i_saddr, i_sdata, i_ssel};
  assign acc    = i_scyc && i_sstb && !stall_q;
  assign issue  = outv && !i_mstall;
  assign ack_ok = i_mack && (cnt_q != '0);
  assign flush  = !i_scyc || err_ev;

`ifdef WBPIPE_SLICE_TIMEOUT_EN
  localparam int             TW       = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmr_q;
  logic          tmo;

  assign tmo    = (cnt_q != '0) && (tmr_q == TMO_LAST);
  assign err_ev = (i_merr && mcyc_q) || tmo;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                              tmr_q <= '0;
    else if (i_mack || cnt_q == '0 || flush)     tmr_q <= '0;
    else                                         tmr_q <= tmr_q + TW'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err_ev = i_merr && mcyc_q;
`endif

  wbpipe_skid #(.T(req_t)) u_skid (
    .clk_i       (i_clk),
    .rst_ni      (i_reset_n),
    .flush_i     (flush),
    .in_valid_i  (acc),
    .in_data_i   (in_req),
    .out_ready_i (!i_mstall),
    .out_valid_o (outv),
    .out_data_o  (out_req),
    .outv_d_o    (outv_d),
    .skv_d_o     (skv_d)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (flush)                                         cnt_d = '0;
    else if (issue && !ack_ok && cnt_q != CNT_MAX[LGDEPTH-1:0]) cnt_d = cnt_q + LGDEPTH'(1);
    else if (!issue && ack_ok)                         cnt_d = cnt_q - LGDEPTH'(1);
    // stall is computed from next-state so the registered flag is exact when seen
    tot_d   = {1'b0, cnt_d} + (LGDEPTH+1)'(outv_d) + (LGDEPTH+1)'(skv_d);
    abort_d = i_scyc && (abort_q || err_ev);
    stall_d = skv_d || abort_d || (tot_d >= CNT_MAX);
    mcyc_d  = flush ? 1'b0 : (acc ? 1'b1 : mcyc_q);
    sack_d  = ack_ok && mcyc_q && i_scyc && !abort_q && !err_ev;
    serr_d  = err_ev && i_scyc && !abort_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      mcyc_q  <= 1'b0;
      stall_q <= 1'b0;
      abort_q <= 1'b0;
      sack_q  <= 1'b0;
      serr_q  <= 1'b0;
      sdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mcyc_q  <= mcyc_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
      sack_q  <= sack_d;
      serr_q  <= serr_d;
      if (i_mack) sdata_q <= i_mdata;
    end
  end

  assign o_sstall = stall_q;
  assign o_sack   = sack_q;
  assign o_serr   = serr_q;
  assign o_sdata  = sdata_q;
  assign o_mcyc   = mcyc_q;
  assign o_mstb   = outv;
  assign o_mwe    = out_req.we;
  assign o_maddr  = out_req.addr;
  assign o_mdata  = out_req.data;
  assign o_msel   = out_req.sel;
endmodule

// File: tb/tb_wbpipe_slice.sv
// Scoreboard bench for wbpipe_slice: queued expected requests/responses, negedge monitor.
module tb_wbpipe_slice;
  localparam int AW = 30;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    sel;
  } req_t;
  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  logic i_clk = 1'b0, i_reset_n = 1'b1;
  logic i_scyc = 1'b0, i_sstb = 1'b0, i_swe = 1'b0;
  logic [AW-1:0] i_saddr = '0;
  logic [DW-1:0] i_sdata = '0;
  logic [3:0]    i_ssel = '0;
  logic o_sstall, o_sack, o_serr, o_mcyc, o_mstb, o_mwe;
  logic [DW-1:0] o_sdata, o_mdata;
  logic [AW-1:0] o_maddr;
  logic [3:0]    o_msel;
  logic i_mstall = 1'b0, i_merr = 1'b0;
  logic i_mack;
  logic [DW-1:0] i_mdata;

  logic man_ack = 1'b0, auto_en = 1'b0, auto_pend = 1'b0;
  logic [DW-1:0] man_dat = '0, auto_dat = '0;
  assign i_mack  = man_ack | auto_pend;
  assign i_mdata = auto_pend ? auto_dat : man_dat;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t mr;
  rsp_t ms;
  int n_chk = 0, n_fail = 0, n_iss = 0;

  wbpipe_slice #(.AW(AW), .DW(DW), .LGDEPTH(2), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
    .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
    .o_sstall(o_sstall), .o_sack(o_sack), .o_sdata(o_sdata), .o_serr(o_serr),
    .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe),
    .o_maddr(o_maddr), .o_mdata(o_mdata), .o_msel(o_msel),
    .i_mstall(i_mstall), .i_mack(i_mack), .i_merr(i_merr), .i_mdata(i_mdata)
  );

  always #5 i_clk = ~i_clk;

  // downstream responder: acks every issued request one cycle later with its address as data
  always @(posedge i_clk) begin
    auto_pend <= auto_en && o_mstb && !i_mstall;
    auto_dat  <= {2'b00, o_maddr};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_mstb && !i_mstall) begin
        n_iss++;
        if (exp_req.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL req_unexpected: addr 0x%0h issued, no request expected", o_maddr);
        end else begin
          mr = exp_req.pop_front();
          chk("req_addr", 64'(o_maddr), 64'(mr.addr));
          chk("req_attr", 64'({o_mwe, o_msel, o_mdata}), 64'({mr.we, mr.sel, mr.data}));
        end
      end
      if (o_sack || o_serr) begin
        chk("ack_err_exclusive", 64'(o_sack & o_serr), 64'(0));
        if (exp_rsp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rsp_unexpected: sack=%0b serr=%0b, no response expected", o_sack, o_serr);
        end else begin
          ms = exp_rsp.pop_front();
          chk("rsp_err", 64'(o_serr), 64'(ms.err));
          if (o_sack) chk("rsp_data", 64'(o_sdata), 64'(ms.data));
        end
      end
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int waits);
    i_sstb = 1'b1; i_swe = we; i_saddr = a; i_sdata = d; i_ssel = 4'hF; waits = 0;
    while (o_sstall && waits < 50) begin tick(); waits++; end
    if (o_sstall) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: addr 0x%0h stalled %0d cycles, expected accept", a, waits);
    end else exp_req.push_back({we, a, d, 4'hF});
    tick();
    i_sstb = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_req.size() != 0 || exp_rsp.size() != 0) && n < 60) begin tick(); n++; end
    chk({nm, "_req_left"}, 64'(exp_req.size()), 64'(0));
    chk({nm, "_rsp_left"}, 64'(exp_rsp.size()), 64'(0));
    exp_req.delete();
    exp_rsp.delete();
  endtask

  initial begin
    int w, wsum, base;
    logic saw;
    #1 i_reset_n = 1'b0;
    #20;
    chk("rst_sstall", 64'(o_sstall), 0);
    chk("rst_sack", 64'(o_sack), 0);
    chk("rst_serr", 64'(o_serr), 0);
    chk("rst_mcyc", 64'(o_mcyc), 0);
    chk("rst_mstb", 64'(o_mstb), 0);
    chk("rst_maddr", 64'(o_maddr), 0);
    chk("rst_msel", 64'(o_msel), 0);
    chk("rst_sdata", 64'(o_sdata), 0);
    tick(); i_reset_n = 1'b1; tick(); tick();

    // single read, exact latencies
    i_scyc = 1; i_sstb = 1; i_swe = 0; i_saddr = 30'h10; i_sdata = 0; i_ssel = 4'hF;
    exp_req.push_back({1'b0, 30'h10, 32'h0, 4'hF});
    chk("t1_mstb_c0", 64'(o_mstb), 0);
    tick(); i_sstb = 0;
    chk("t1_mstb_c1", 64'(o_mstb), 1);
    chk("t1_maddr_c1", 64'(o_maddr), 64'h10);
    chk("t1_mcyc_c1", 64'(o_mcyc), 1);
    tick(); man_ack = 1; man_dat = 32'hDEADBEEF;
    exp_rsp.push_back({1'b0, 32'hDEADBEEF});
    chk("t1_sack_c2", 64'(o_sack), 0);
    tick(); man_ack = 0;
    chk("t1_sack_c3", 64'(o_sack), 1);
    chk("t1_sdata_c3", 64'(o_sdata), 64'hDEADBEEF);
    tick();
    chk("t1_sack_c4", 64'(o_sack), 0);
    i_scyc = 0; tick();
    chk("t1_mcyc_drop", 64'(o_mcyc), 0);
    drain("t1");

    // burst of 8 writes with a 3-cycle downstream stall in the middle
    auto_en = 1; i_scyc = 1; base = n_iss;
    for (int i = 0; i < 8; i++) exp_rsp.push_back({1'b0, 32'h100 + 32'(i)});
    fork
      begin
        for (int i = 0; i < 8; i++) send(1'b1, 30'h100 + 30'(i), 32'hA000_0000 + 32'(i), w);
      end
      begin
        repeat (3) tick();
        i_mstall = 1;
        tick();
        chk("t2_sstall_after_skid", 64'(o_sstall), 1);
        repeat (2) tick();
        i_mstall = 0;
      end
    join
    drain("t2");
    chk("t2_issued", 64'(n_iss - base), 8);
    auto_en = 0; i_scyc = 0; tick(); tick();

    // outstanding limit of 3 with LGDEPTH=2
    i_scyc = 1; base = n_iss;
    fork
      begin
        for (int i = 0; i < 5; i++) send(1'b0, 30'h20 + 30'(i), 32'h0, w);
      end
      begin
        repeat (8) tick();
        chk("t3_issued_full", 64'(n_iss - base), 3);
        chk("t3_stall_full", 64'(o_sstall), 1);
        for (int k = 1; k <= 5; k++) begin
          exp_rsp.push_back({1'b0, 32'h3000_0000 + 32'(k)});
          man_ack = 1; man_dat = 32'h3000_0000 + 32'(k);
          tick(); man_ack = 0;
          repeat (3) tick();
          if (k == 1) begin
            chk("t3_issued_after_ack", 64'(n_iss - base), 4);
            chk("t3_stall_again", 64'(o_sstall), 1);
          end
        end
      end
    join
    drain("t3");
    chk("t3_issued_total", 64'(n_iss - base), 5);
    i_scyc = 0; tick(); tick();

    // downstream error with 2 outstanding
    i_scyc = 1; base = n_iss;
    send(1'b0, 30'h40, 32'h0, w);
    send(1'b0, 30'h41, 32'h0, w);
    tick(); tick();
    exp_rsp.push_back({1'b1, 32'h0});
    i_merr = 1; tick(); i_merr = 0;
    chk("t4_serr", 64'(o_serr), 1);
    chk("t4_mcyc_drop", 64'(o_mcyc), 0);
    chk("t4_mstb_drop", 64'(o_mstb), 0);
    chk("t4_stall_abort", 64'(o_sstall), 1);
    man_ack = 1; man_dat = 32'h4444_4444; tick(); man_ack = 0;
    chk("t4_serr_one_cycle", 64'(o_serr), 0);
    tick();
    chk("t4_no_late_sack", 64'(o_sack), 0);
    i_sstb = 1; i_saddr = 30'h42; tick();
    chk("t4_stall_held", 64'(o_sstall), 1);
    chk("t4_mstb_held", 64'(o_mstb), 0);
    repeat (3) tick();
    chk("t4_issued", 64'(n_iss - base), 2);
    i_sstb = 0; i_scyc = 0; tick();
    chk("t4_stall_release", 64'(o_sstall), 0);
    drain("t4");

    // upstream cycle drop with one outstanding, output stalled and skid full
    i_scyc = 1; i_swe = 0; i_sdata = 0; i_ssel = 4'hF;
    i_sstb = 1; i_saddr = 30'h50;
    exp_req.push_back({1'b0, 30'h50, 32'h0, 4'hF});
    tick(); i_saddr = 30'h51;
    tick(); i_mstall = 1; i_saddr = 30'h52;
    tick();
    chk("t5_stall_skid", 64'(o_sstall), 1);
    chk("t5_held_addr", 64'(o_maddr), 64'h51);
    i_sstb = 0; i_scyc = 0; tick();
    chk("t5_mcyc_drop", 64'(o_mcyc), 0);
    chk("t5_mstb_drop", 64'(o_mstb), 0);
    chk("t5_stall_clear", 64'(o_sstall), 0);
    man_ack = 1; man_dat = 32'h5555_5555; tick(); man_ack = 0; i_mstall = 0;
    chk("t5_late_ack_dropped", 64'(o_sack), 0);
    i_scyc = 1; wsum = 0;
    for (int i = 0; i < 3; i++) begin send(1'b0, 30'h60 + 30'(i), 32'h0, w); wsum += w; end
    chk("t5_fresh_no_wait", 64'(wsum), 0);
    for (int k = 0; k < 3; k++) begin
      exp_rsp.push_back({1'b0, 32'h6000_0000 + 32'(k)});
      man_ack = 1; man_dat = 32'h6000_0000 + 32'(k); tick();
    end
    man_ack = 0;
    drain("t5");
    i_scyc = 0; tick(); tick();

    // unacked read: forced error only when the timeout is built in
    i_scyc = 1;
`ifdef WBPIPE_SLICE_TIMEOUT_EN
    exp_rsp.push_back({1'b1, 32'h0});
    send(1'b0, 30'h70, 32'h0, w);
    tick();
    w = 0;
    while (!o_serr && w < 40) begin tick(); w++; end
    chk("t6_timeout_cycles", 64'(w), 16);
`else
    send(1'b0, 30'h70, 32'h0, w);
    saw = 1'b0;
    repeat (100) begin tick(); saw = saw | o_serr; end
    chk("t6_no_timeout", 64'(saw), 0);
`endif
    i_scyc = 0; tick(); tick();
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
